// File: rtl/audio_vol_pkg.sv
// rtl/audio_vol_pkg.sv - shared constants, gain table and FSM encoding for audio_vol_ctrl
//
// Purpose: widths, the volume-index to linear-gain table (~1.5 dB/step,
// index 31 = unity, index 0 = silence) and the button FSM state encoding.
// Ports: none (package).
package audio_vol_pkg;

  localparam int VOL_W  = 5;
  localparam int GAIN_W = 16;

  localparam logic [VOL_W-1:0]  VOL_MAX    = 5'd31;
  localparam logic [GAIN_W-1:0] GAIN_UNITY = 16'h8000;

  // Button sequencer states; plain vector constants keep the encoding explicit.
  typedef logic [1:0] vol_state_t;
  localparam vol_state_t IDLE   = 2'd0;
  localparam vol_state_t HOLD   = 2'd1;
  localparam vol_state_t REPEAT = 2'd2;
  localparam vol_state_t BOTH   = 2'd3;

  // round(32768 * 10^(-1.5*(31-i)/20)); entry 0 forced to 0 for true silence.
  localparam logic [GAIN_W-1:0] GAIN_LUT [0:31] = '{
    16'd0,     16'd184,   16'd219,   16'd260,
    16'd309,   16'd368,   16'd437,   16'd519,
    16'd617,   16'd734,   16'd872,   16'd1036,
    16'd1232,  16'd1464,  16'd1740,  16'd2068,
    16'd2457,  16'd2921,  16'd3471,  16'd4125,
    16'd4903,  16'd5827,  16'd6926,  16'd8231,
    16'd9783,  16'd11627, 16'd13818, 16'd16423,
    16'd19519, 16'd23198, 16'd27571, GAIN_UNITY
  };

endpackage

// File: rtl/vol_gain_ramp.sv
// rtl/vol_gain_ramp.sv - slew limiter that walks the gain word toward its target
//
// Purpose: a free-running divider produces one tick every RAMP_CYCLES clocks;
// on each tick the gain moves at most RAMP_DELTA toward the target, landing
// exactly on it once the remaining distance fits in one step.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   target   in   16-bit gain the output should settle to
//   gain     out  16-bit slewed gain word
//   ramping  out  high while gain != target
module vol_gain_ramp
  import audio_vol_pkg::*;
#(
  parameter int                RAMP_CYCLES = 4000,
  parameter int                RAMP_DELTA  = 512,
  parameter logic [GAIN_W-1:0] GAIN_RST    = GAIN_UNITY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [GAIN_W-1:0] target,
  output logic [GAIN_W-1:0] gain,
  output logic              ramping
);

  localparam int DIV_W = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(RAMP_CYCLES - 1);
  localparam logic [GAIN_W:0]   STEP_17  = (GAIN_W+1)'(RAMP_DELTA);
  localparam logic [GAIN_W-1:0] STEP_16  = GAIN_W'(RAMP_DELTA);

  logic [DIV_W-1:0]         div;
  logic                     tick;
  logic signed [GAIN_W:0]   diff;
  logic [GAIN_W:0]          mag;

  assign tick    = (div == DIV_LAST);
  // 17-bit signed difference so the full 0..0xFFFF range never wraps.
  assign diff    = $signed({1'b0, target}) - $signed({1'b0, gain});
  assign mag     = diff[GAIN_W] ? $unsigned(-diff) : $unsigned(diff);
  assign ramping = (gain != target);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div  <= '0;
      gain <= GAIN_RST;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) begin
        if (mag <= STEP_17) begin
          gain <= target;
        end else if (diff[GAIN_W]) begin
          gain <= gain - STEP_16;
        end else begin
          gain <= gain + STEP_16;
        end
      end
    end
  end

endmodule

// File: rtl/audio_vol_ctrl.sv
// rtl/audio_vol_ctrl.sv - button/CPU volume and mute controller producing a linear gain word
//
// Purpose: sequences vol-/vol+ presses (step, hold auto-repeat, both-button
// mute toggle), accepts CPU volume writes, and drives the output scaler gain.
// Build option: AUDIO_VOL_SOFT_RAMP_EN defined -> gain slews via vol_gain_ramp;
// undefined -> gain is the target registered once, o_ramping tied low.
// Ports:
//   i_clk          in   system clock
//   reset_n        in   asynchronous active-low reset
//   i_btn_dn       in   debounced vol- button, 0 = pressed
//   i_btn_up       in   debounced vol+ button, 0 = pressed
//   i_cpu_we       in   single-cycle CPU volume write strobe
//   i_cpu_vol      in   CPU volume index
//   i_cpu_mute     in   CPU mute level, ORed with button mute
//   o_vol          out  current volume index
//   o_mute         out  effective mute
//   o_gain         out  linear gain, 0x8000 = unity
//   o_ramping      out  high while o_gain differs from its target
//   o_vol_changed  out  one-cycle pulse on a volume or button-mute change
module audio_vol_ctrl
  import audio_vol_pkg::*;
#(
  parameter int HOLD_CYCLES   = 20000000,
  parameter int REPEAT_CYCLES = 4000000,
  parameter int RAMP_CYCLES   = 4000,
  parameter int RAMP_DELTA    = 512,
  parameter int VOL_DEFAULT   = 24
) (
  input  logic              i_clk,
  input  logic              reset_n,
  input  logic              i_btn_dn,
  input  logic              i_btn_up,
  input  logic              i_cpu_we,
  input  logic [VOL_W-1:0]  i_cpu_vol,
  input  logic              i_cpu_mute,
  output logic [VOL_W-1:0]  o_vol,
  output logic              o_mute,
  output logic [GAIN_W-1:0] o_gain,
  output logic              o_ramping,
  output logic              o_vol_changed
);

  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [VOL_W-1:0]  VOL_RST     = VOL_W'(VOL_DEFAULT);
  localparam logic [GAIN_W-1:0] GAIN_RST    = GAIN_LUT[VOL_DEFAULT];

  // Button sample (s) and its previous value (d); a press is a 1->0 edge.
  logic dn_s, dn_d, up_s, up_d;
  logic press_dn, press_up, any_press;
  logic dn_held, up_held, both_held, dir_held;

  vol_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              dir_up, dir_up_nxt;
  logic              step_req, step_up, mute_tgl;
  logic              btn_mute;
  logic [VOL_W-1:0]  vol_nxt;
  logic [GAIN_W-1:0] target;

  assign press_dn  = dn_d & ~dn_s;
  assign press_up  = up_d & ~up_s;
  assign any_press = press_dn | press_up;
  assign dn_held   = ~dn_s;
  assign up_held   = ~up_s;
  assign both_held = dn_held & up_held;
  assign dir_held  = dir_up ? up_held : dn_held;
  // From IDLE the direction comes from the edge itself; afterwards from the latch.
  assign step_up   = (state == IDLE) ? press_up : dir_up;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    dir_up_nxt = dir_up;
    step_req   = 1'b0;
    mute_tgl   = 1'b0;
    case (state)
      IDLE: begin
        if (any_press) begin
          if (both_held) begin
            mute_tgl  = 1'b1;
            state_nxt = BOTH;
          end else begin
            step_req   = 1'b1;
            dir_up_nxt = press_up;
            cnt_nxt    = '0;
            state_nxt  = HOLD;
          end
        end
      end
      HOLD, REPEAT: begin
        if (any_press && both_held) begin
          mute_tgl  = 1'b1;
          state_nxt = BOTH;
        end else if (!dir_held) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (cnt == ((state == HOLD) ? HOLD_LAST : REPEAT_LAST)) begin
          step_req  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = REPEAT;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      BOTH: begin
        if (!dn_held && !up_held) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // CPU write wins over a same-cycle button step; steps saturate at 0/31.
  always_comb begin
    vol_nxt = o_vol;
    if (i_cpu_we) begin
      vol_nxt = i_cpu_vol;
    end else if (step_req) begin
      if (step_up) begin
        if (o_vol != VOL_MAX) vol_nxt = o_vol + VOL_W'(1);
      end else begin
        if (o_vol != '0) vol_nxt = o_vol - VOL_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      dn_s          <= 1'b1;
      dn_d          <= 1'b1;
      up_s          <= 1'b1;
      up_d          <= 1'b1;
      state         <= IDLE;
      cnt           <= '0;
      dir_up        <= 1'b0;
      btn_mute      <= 1'b0;
      o_vol         <= VOL_RST;
      o_vol_changed <= 1'b0;
    end else begin
      dn_s          <= i_btn_dn;
      dn_d          <= dn_s;
      up_s          <= i_btn_up;
      up_d          <= up_s;
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      dir_up        <= dir_up_nxt;
      btn_mute      <= btn_mute ^ mute_tgl;
      o_vol         <= vol_nxt;
      o_vol_changed <= (vol_nxt != o_vol) | mute_tgl;
    end
  end

  assign o_mute = btn_mute | i_cpu_mute;
  assign target = o_mute ? '0 : GAIN_LUT[o_vol];

`ifdef AUDIO_VOL_SOFT_RAMP_EN
  vol_gain_ramp #(
    .RAMP_CYCLES (RAMP_CYCLES),
    .RAMP_DELTA  (RAMP_DELTA),
    .GAIN_RST    (GAIN_RST)
  ) u_ramp (
    .clk     (i_clk),
    .rst_n   (reset_n),
    .target  (target),
    .gain    (o_gain),
    .ramping (o_ramping)
  );
`else
  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      o_gain <= GAIN_RST;
    end else begin
      o_gain <= target;
    end
  end
  assign o_ramping = 1'b0;
`endif

endmodule
